rx_edge_sampler: RTL and testbench
==================================

# rx_edge_sampler

Oversampling front end of the UART receive path. It synchronizes the asynchronous `RX_IN` line and runs the per-bit edge counter and the per-frame bit counter. It also produces a majority-voted `sampled_bit` near mid-bit. It sits directly upstream of the deserializer, parity check and stop check, and feeds them `sampled_bit`, `edge_cnt` and `bit_cnt` under control of the RX FSM.

## Interface
Parameters:
- `CNT_W`, default 6: edge counter width; must hold max prescale minus 1 (31).

Ports (reset RST, synchronous, active-low; clock CLK):
- `CLK` in 1: system clock (prescale × baud).
- `RST` in 1: synchronous active-low reset.
- `RX_IN` in 1: asynchronous serial line, idle high.
- `prescale` in 6: oversampling ratio; legal 8, 16, 32.
- `PAR_EN` in 1: frame carries a parity bit.
- `cnt_en` in 1: FSM enable for the counters; level.
- `dat_samp_en` in 1: FSM enable for the sampler; level.
- `rx_sync` out 1: synchronized `RX_IN`, for FSM start detection.
- `edge_cnt` out `CNT_W`: oversample index within the current bit, 0..P-1.
- `bit_cnt` out 4: bit index within the frame; 0 is the start bit.
- `sampled_bit` out 1: voted bit value.
- `sample_valid` out 1: one-cycle pulse when `sampled_bit` is updated.
- `frame_done` out 1: one-cycle pulse at the last edge of the stop bit.

## Operation
- Synchronizer: two flops, both reset to 1. `rx_sync` lags `RX_IN` by 2 cycles.
- Prescale latch:
  - Effective prescale P is captured from `prescale` in every cycle where `cnt_en` = 0.
  - It is frozen while `cnt_en` = 1.
  - Values other than 16 or 32 decode to P = 8.
  - Reset value of P is 8.
- Frame length: L = 10 + `PAR_EN` (start, 8 data, optional parity, stop). `PAR_EN` is latched with P.
- Edge counter:
  - While `cnt_en` = 1, `edge_cnt` increments each cycle.
  - At P-1 it wraps to 0 and `bit_cnt` increments.
- End of frame:
  - When `bit_cnt` = L-1 and `edge_cnt` = P-1, both counters clear and `frame_done` pulses the same cycle.
  - Counting continues from 0 if `cnt_en` stays high.
- `cnt_en` = 0: `edge_cnt` and `bit_cnt` go to 0 on the next edge, overriding any increment.
- Sampler, with H = P/2:
  - `rx_sync` is captured into three sample flops at `edge_cnt` = H-1, H and H+1.
  - The 2-of-3 majority is registered into `sampled_bit` on the cycle after `edge_cnt` = H+1.
  - `sample_valid` pulses in that same cycle. `sampled_bit` is therefore stable while `edge_cnt` = H+2..P-1; for P = 8 it is valid at `edge_cnt` = 7.
- `dat_samp_en` = 0:
  - Sample flops and `sampled_bit` hold their values.
  - `sample_valid` stays 0.
  - Counters are unaffected.
- Reset values: `edge_cnt` 0, `bit_cnt` 0, `sampled_bit` 1, `sample_valid` 0, `frame_done` 0, sample flops 1, `rx_sync` 1.
- Reset mid-frame: all state returns to reset values on the next edge, and no pulses are emitted.

## Timing
- Input to `rx_sync`: 2 cycles.
- Sample to `sampled_bit`: 1 cycle after the last sample point (`edge_cnt` = H+1).
- `bit_cnt` changes on the same edge that `edge_cnt` wraps from P-1 to 0.
- Simultaneous end of frame and `cnt_en` falling: counters clear and `frame_done` still pulses.
- Simultaneous `cnt_en` low and `edge_cnt` = P-1: counters clear, and `bit_cnt` does not increment.
- `cnt_en` rising: the first counted cycle has `edge_cnt` = 0. The FSM asserts `cnt_en` on the cycle after it sees `rx_sync` fall.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `RX_MAJORITY_VOTE_EN` defined: three-sample 2-of-3 vote as above.
- `RX_MAJORITY_VOTE_EN` undefined:
  - A single sample is taken at `edge_cnt` = H and registered into `sampled_bit` the next cycle.
  - `sample_valid` pulses at `edge_cnt` = H+1.
  - The H-1 and H+1 sample flops are not instantiated.
- The counters and synchronizer are identical in both builds.

## Structure
- Shared package `uart_rx_pkg`:
  - prescale constants PRESC_8/16/32;
  - frame length constants FRAME_LEN_NOPAR (10) and FRAME_LEN_PAR (11);
  - the prescale decode function.
- One sub-module: `uart_rx_sync`, the 2-flop synchronizer with reset value 1. Counters and sampler stay inline.

## Test plan
- Reset and idle:
  - Hold `RST` = 0 for 3 cycles with `RX_IN` = 0.
  - Required: `sampled_bit` = 1, counters 0, `rx_sync` = 1 after release until 2 cycles later.
- P = 8, `PAR_EN` = 0, frame 0xA5 LSB-first, `cnt_en`/`dat_samp_en` high:
  - Required: `sampled_bit` = the bit value at `edge_cnt` = 7 for `bit_cnt` 1..8.
  - Required: `frame_done` pulses once at `bit_cnt` = 9, `edge_cnt` = 7 (80 counted cycles).
- P = 16, `PAR_EN` = 1:
  - Required: `frame_done` after 176 cycles.
  - Required: `sample_valid` at `edge_cnt` = 10 of every bit.
  - Change `prescale` to 32 mid-frame. Required: no effect until `cnt_en` drops.
- Glitch, with `RX_MAJORITY_VOTE_EN`:
  - Force `rx_sync` low only at the `edge_cnt` = H sample point of a high bit.
  - Required: `sampled_bit` = 1. Without the macro, `sampled_bit` = 0.
- Abort:
  - Drop `cnt_en` at `bit_cnt` = 4, `edge_cnt` = 5.
  - Required: both counters 0 next cycle, no `frame_done`. Re-assert: `edge_cnt` restarts at 0.
- Illegal prescale:
  - `prescale` = 12.
  - Required: behaves as P = 8 (`edge_cnt` wraps at 7).

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: prescale and frame-length constants plus the prescale decode shared by the UART receive path
package uart_rx_pkg;
  localparam logic [5:0] PRESC_8 = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;
  localparam logic [3:0] FRAME_LEN_NOPAR = 4'd10;
  localparam logic [3:0] FRAME_LEN_PAR = 4'd11;
  function automatic logic [5:0] decode_prescale(input logic [5:0] p);
    return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the idle-high serial line
module uart_rx_sync (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the raw line through two flops; both park at the idle level in reset
  always_ff @(posedge CLK)
    if (!RST) {q, meta} <= 2'b11;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/rx_edge_sampler.sv
// rx_edge_sampler: UART RX oversampling counters and mid-bit sampler; RX_MAJORITY_VOTE_EN selects the 2-of-3 vote
module rx_edge_sampler
  import uart_rx_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic [5:0]       prescale,
  input  logic             PAR_EN,
  input  logic             cnt_en,
  input  logic             dat_samp_en,
  output logic             rx_sync,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [3:0]       bit_cnt,
  output logic             sampled_bit,
  output logic             sample_valid,
  output logic             frame_done
);
  logic [5:0] p_reg;
  logic par_reg;
  logic [CNT_W-1:0] p_last, h, h_lo, h_hi;
  logic [3:0] bit_last;
  logic edge_wrap, frame_end;

  uart_rx_sync u_sync (.CLK(CLK), .RST(RST), .d(RX_IN), .q(rx_sync));

  assign p_last = CNT_W'(p_reg - 6'd1);
  assign h = CNT_W'(p_reg >> 1);
  assign h_lo = h - CNT_W'(1);
  assign h_hi = h + CNT_W'(1);
  assign bit_last = par_reg ? FRAME_LEN_PAR - 4'd1 : FRAME_LEN_NOPAR - 4'd1;
  assign edge_wrap = edge_cnt == p_last;
  assign frame_end = edge_wrap && bit_cnt == bit_last;

  // track prescale and parity while idle, freeze them for the whole counted frame
  always_ff @(posedge CLK)
    if (!RST) begin
      p_reg <= PRESC_8;
      par_reg <= 1'b0;
    end else if (!cnt_en) begin
      p_reg <= decode_prescale(prescale);
      par_reg <= PAR_EN;
    end

  // edge/bit counters; a dropped enable or the last edge of the stop bit clears both
  always_ff @(posedge CLK)
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      edge_cnt <= (!cnt_en || edge_wrap) ? '0 : edge_cnt + CNT_W'(1);
      bit_cnt <= (!cnt_en || frame_end) ? 4'd0 : edge_wrap ? bit_cnt + 4'd1 : bit_cnt;
    end

`ifdef RX_MAJORITY_VOTE_EN
  logic s_lo, s_mid;
  // sample at H-1 and H, then vote them with the H+1 sample straight into sampled_bit
  always_ff @(posedge CLK)
    if (!RST) begin
      s_lo <= 1'b1;
      s_mid <= 1'b1;
      sampled_bit <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= dat_samp_en && edge_cnt == h_hi;
      if (dat_samp_en && edge_cnt == h_lo) s_lo <= rx_sync;
      if (dat_samp_en && edge_cnt == h) s_mid <= rx_sync;
      if (dat_samp_en && edge_cnt == h_hi)
        sampled_bit <= (s_lo & s_mid) | (s_lo & rx_sync) | (s_mid & rx_sync);
    end
`else
  logic unused_h;
  assign unused_h = ^{h_lo, h_hi};
  // single sample at mid-bit goes straight into sampled_bit
  always_ff @(posedge CLK)
    if (!RST) begin
      sampled_bit <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= dat_samp_en && edge_cnt == h;
      if (dat_samp_en && edge_cnt == h) sampled_bit <= rx_sync;
    end
`endif
endmodule

// File: tb/tb_rx_edge_sampler.sv
// tb_rx_edge_sampler: directed bench with a queue of expected voted bits for rx_edge_sampler
module tb_rx_edge_sampler;
  logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, cnt_en = 1'b0, dat_samp_en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic rx_sync, sampled_bit, sample_valid, frame_done;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  int errors = 0, checks = 0, sv_edge = 6;
  logic exp_q[$];

`ifdef RX_MAJORITY_VOTE_EN
  localparam int SV_OFS = 2;
  localparam logic GLITCH_BIT = 1'b1;
`else
  localparam int SV_OFS = 1;
  localparam logic GLITCH_BIT = 1'b0;
`endif

  rx_edge_sampler dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale), .PAR_EN(PAR_EN),
    .cnt_en(cnt_en), .dat_samp_en(dat_samp_en), .rx_sync(rx_sync), .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt), .sampled_bit(sampled_bit), .sample_valid(sample_valid), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK)
    if (sample_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'(sample_valid), 32'(0));
      else chk("sampled_bit", 32'(sampled_bit), 32'(exp_q.pop_front()));
      chk("valid_edge", 32'(edge_cnt), 32'(sv_edge));
    end

  task automatic run_frame(input int p, input logic [5:0] pres, input logic par, input logic [7:0] data,
                           input int chg_at, input logic [5:0] chg_val, input int glitch_at);
    logic [10:0] bits;
    int len;
    len = 10 + int'(par);
    bits = par ? {1'b1, ^data, data, 1'b0} : {2'b11, data, 1'b0};
    prescale = pres;
    PAR_EN = par;
    dat_samp_en = 1'b1;
    sv_edge = p / 2 + SV_OFS;
    for (int c = 0; c <= len * p + 1; c++) begin
      int k = c / p;
      int n;
      RX_IN = (k < len) ? bits[k] : 1'b1;
      if (c == glitch_at) RX_IN = 1'b0;
      if (c == chg_at) prescale = chg_val;
      if (c == 2) cnt_en = 1'b1;
      if (c % p == 0 && k < len) exp_q.push_back(glitch_at == k * p + p / 2 ? GLITCH_BIT : bits[k]);
      tick;
      n = c >= 2 ? c - 1 : 0;
      chk("frame_done", 32'(frame_done), 32'(n == len * p));
      chk("edge_cnt", 32'(edge_cnt), 32'(n % p));
      chk("bit_cnt", 32'(bit_cnt), 32'((n / p) % len));
    end
    cnt_en = 1'b0;
    dat_samp_en = 1'b0;
    tick;
    chk("queue_drain", 32'(exp_q.size()), 32'(0));
    chk("idle_edge", 32'(edge_cnt), 32'(0));
  endtask

  initial begin
    RX_IN = 1'b0;
    repeat (3) tick;
    chk("rst_sampled", 32'(sampled_bit), 32'(1));
    chk("rst_edge", 32'(edge_cnt), 32'(0));
    chk("rst_bit", 32'(bit_cnt), 32'(0));
    chk("rst_sync", 32'(rx_sync), 32'(1));
    chk("rst_valid", 32'(sample_valid), 32'(0));
    chk("rst_done", 32'(frame_done), 32'(0));
    RST = 1'b1;
    tick;
    chk("sync_lag1", 32'(rx_sync), 32'(1));
    tick;
    chk("sync_lag2", 32'(rx_sync), 32'(0));
    RX_IN = 1'b1;
    repeat (2) tick;
    chk("sync_idle", 32'(rx_sync), 32'(1));

    run_frame(8, 6'd8, 1'b0, 8'hA5, -1, 6'd0, -1);
    run_frame(16, 6'd16, 1'b1, 8'h5C, 50, 6'd32, -1);
    cnt_en = 1'b1;
    repeat (17) tick;
    chk("p32_after_drop", 32'(edge_cnt), 32'(17));
    cnt_en = 1'b0;
    tick;
    run_frame(32, 6'd32, 1'b0, 8'h81, -1, 6'd0, -1);
    run_frame(8, 6'd8, 1'b0, 8'hA5, -1, 6'd0, 12);
    run_frame(8, 6'd12, 1'b1, 8'h3C, -1, 6'd0, -1);

    prescale = 6'd8;
    PAR_EN = 1'b0;
    tick;
    cnt_en = 1'b1;
    repeat (37) tick;
    chk("abort_pre_edge", 32'(edge_cnt), 32'(5));
    chk("abort_pre_bit", 32'(bit_cnt), 32'(4));
    cnt_en = 1'b0;
    tick;
    chk("abort_edge", 32'(edge_cnt), 32'(0));
    chk("abort_bit", 32'(bit_cnt), 32'(0));
    chk("abort_done", 32'(frame_done), 32'(0));
    cnt_en = 1'b1;
    chk("restart_edge0", 32'(edge_cnt), 32'(0));
    tick;
    chk("restart_edge1", 32'(edge_cnt), 32'(1));
    cnt_en = 1'b0;
    tick;

    cnt_en = 1'b1;
    repeat (79) tick;
    chk("end_pre_bit", 32'(bit_cnt), 32'(9));
    chk("end_pre_edge", 32'(edge_cnt), 32'(7));
    cnt_en = 1'b0;
    tick;
    chk("end_drop_done", 32'(frame_done), 32'(1));
    chk("end_drop_edge", 32'(edge_cnt), 32'(0));
    chk("end_drop_bit", 32'(bit_cnt), 32'(0));
    tick;
    chk("end_drop_once", 32'(frame_done), 32'(0));

    cnt_en = 1'b1;
    RX_IN = 1'b0;
    repeat (20) tick;
    RST = 1'b0;
    tick;
    chk("midrst_edge", 32'(edge_cnt), 32'(0));
    chk("midrst_bit", 32'(bit_cnt), 32'(0));
    chk("midrst_sync", 32'(rx_sync), 32'(1));
    chk("midrst_sampled", 32'(sampled_bit), 32'(1));
    chk("midrst_done", 32'(frame_done), 32'(0));
    RST = 1'b1;
    cnt_en = 1'b0;
    RX_IN = 1'b1;
    repeat (2) tick;
    chk("final_queue", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
